// File: rtl/logic_unit_pkg.sv
// Shared definitions for the sliced logic unit: operation encodings and the
// controller state type.
package logic_unit_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/sliced_logic_unit_slice_logic.sv
// One SLICE-bit lane of the logic unit; shared by every slice of an operation,
// so it is purely combinational.
module slice_logic
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  input  logic [1:0]       op,
  output logic [SLICE-1:0] y_s
);

  // Select the bitwise function for this lane.
  always_comb begin
    y_s = {SLICE{1'b0}};
    case (op)
      OP_AND:  y_s = a_s & b_s;
      OP_OR:   y_s = a_s | b_s;
      OP_XOR:  y_s = a_s ^ b_s;
      OP_NOR:  y_s = ~(a_s | b_s);
      default: y_s = {SLICE{1'b0}};
    endcase
  end

endmodule

// File: rtl/sliced_logic_unit.sv
// Multi-cycle bitwise logic unit: one SLICE-bit slice per clock, LSB first.
// Optional zero-result flag port enabled by SLICED_LOGIC_ZERO_FLAG_EN.
module sliced_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
`ifdef SLICED_LOGIC_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NSLICE = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE{1'b1}});
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NSLICE - 1);

  if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
    $error("sliced_logic_unit: WIDTH must be a positive multiple of SLICE");
  end

  state_e           state_r, state_nx_s;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] a_r, b_r, out_r;
  logic [1:0]       op_r;
  logic             in_ready_r, out_valid_r, busy_r;
  logic             accept_s, last_s;
  int               sh_s;
  logic [WIDTH-1:0] a_sh_s, b_sh_s, out_wr_s;
  logic [SLICE-1:0] y_s;

  // Next-state decode; accept only while the registered ready is high.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s   = 1'b1;
          state_nx_s = BUSY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        if (idx_r == LAST_IDX) begin
          last_s     = 1'b1;
          state_nx_s = DONE;
        end else begin
          state_nx_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Route the indexed slice through the shared lane and merge it into out.
  always_comb begin
    sh_s     = int'(idx_r) * SLICE;
    a_sh_s   = a_r >> sh_s;
    b_sh_s   = b_r >> sh_s;
    out_wr_s = (out_r & ~(SMASK << sh_s)) | (WIDTH'(y_s) << sh_s);
  end

  slice_logic #(.SLICE(SLICE)) u_slice (
    .a_s (a_sh_s[SLICE-1:0]),
    .b_s (b_sh_s[SLICE-1:0]),
    .op  (op_r),
    .y_s (y_s)
  );

  // Controller state and handshake outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == DONE);
      busy_r      <= (state_nx_s == BUSY);
    end
  end

  // Operand capture and slice-by-slice result build; out is cleared on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      op_r  <= 2'b00;
      idx_r <= {IDXW{1'b0}};
      out_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      a_r   <= a;
      b_r   <= b;
      op_r  <= op;
      idx_r <= {IDXW{1'b0}};
      out_r <= {WIDTH{1'b0}};
    end else if (state_r == BUSY) begin
      out_r <= out_wr_s;
      idx_r <= last_s ? {IDXW{1'b0}} : (idx_r + IDXW'(1));
    end
  end

`ifdef SLICED_LOGIC_ZERO_FLAG_EN
  logic zero_acc_r, zero_acc_nx_s, zero_r;

  // Running AND of per-slice all-zero terms.
  always_comb begin
    if (accept_s) begin
      zero_acc_nx_s = 1'b1;
    end else if (state_r == BUSY) begin
      zero_acc_nx_s = zero_acc_r & (y_s == {SLICE{1'b0}});
    end else begin
      zero_acc_nx_s = zero_acc_r;
    end
  end

  // Accumulator plus a port copy that is only exposed alongside out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_acc_r <= 1'b1;
      zero_r     <= 1'b0;
    end else begin
      zero_acc_r <= zero_acc_nx_s;
      zero_r     <= (state_nx_s == DONE) && zero_acc_nx_s;
    end
  end

  assign zero = zero_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out       = out_r;

endmodule

// File: tb/tb_sliced_logic_unit.sv
// Self-checking bench: three configurations (32/4, 16/16, 64/8) driven in
// lockstep from shared controls, checked against a bitwise reference model.
module tb_sliced_logic_unit;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [63:0] a, b;
  logic [1:0]  op;

  logic        in_ready32, out_valid32, busy32;
  logic [31:0] out32;
  logic        in_ready16, out_valid16, busy16;
  logic [15:0] out16;
  logic        in_ready64, out_valid64, busy64;
  logic [63:0] out64;
`ifdef SLICED_LOGIC_ZERO_FLAG_EN
  logic        zero32, zero16, zero64;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sliced_logic_unit #(.WIDTH(32), .SLICE(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a[31:0]), .b(b[31:0]), .op(op), .out_valid(out_valid32),
    .out_ready(out_ready), .out(out32), .busy(busy32)
`ifdef SLICED_LOGIC_ZERO_FLAG_EN
    , .zero(zero32)
`endif
  );

  sliced_logic_unit #(.WIDTH(16), .SLICE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a[15:0]), .b(b[15:0]), .op(op), .out_valid(out_valid16),
    .out_ready(out_ready), .out(out16), .busy(busy16)
`ifdef SLICED_LOGIC_ZERO_FLAG_EN
    , .zero(zero16)
`endif
  );

  sliced_logic_unit #(.WIDTH(64), .SLICE(8)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .a(a), .b(b), .op(op), .out_valid(out_valid64),
    .out_ready(out_ready), .out(out64), .busy(busy64)
`ifdef SLICED_LOGIC_ZERO_FLAG_EN
    , .zero(zero64)
`endif
  );

  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic [1:0] o);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with every unit idle; returns at the negedge after accept.
  task automatic accept_op(input logic [63:0] na, input logic [63:0] nb, input logic [1:0] nop);
    a = na; b = nb; op = nop; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    op = ~nop;
  endtask

  // Walks k = 1..9 cycles after accept, out_ready assumed high throughout.
  task automatic complete(input logic [63:0] ea, input logic [63:0] eb, input logic [1:0] eop);
    logic [63:0] r;
    r = model(ea, eb, eop);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("ov32", out_valid32, 64'(k == 8));
      chk("ir32", in_ready32, 64'(k > 8));
      chk("busy32", busy32, 64'(k < 8));
      if (k == 8) chk("out32", out32, {32'h0, r[31:0]});
      chk("ov16", out_valid16, 64'(k == 1));
      chk("busy16", busy16, 64'b0);
      if (k == 1) chk("out16", out16, {48'h0, r[15:0]});
      chk("ov64", out_valid64, 64'(k == 8));
      if (k == 8) chk("out64", out64, r);
`ifdef SLICED_LOGIC_ZERO_FLAG_EN
      chk("zero32", zero32, 64'((k == 8) && (r[31:0] == 32'h0)));
      chk("zero16", zero16, 64'((k == 1) && (r[15:0] == 16'h0)));
      chk("zero64", zero64, 64'((k == 8) && (r == 64'h0)));
`endif
    end
  endtask

  task automatic run_op(input logic [63:0] na, input logic [63:0] nb, input logic [1:0] nop);
    accept_op(na, nb, nop);
    complete(na, nb, nop);
  endtask

  initial begin
    logic [63:0] ra, rb, na, nb;
    logic [1:0]  rop;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 64'h0; b = 64'h0; op = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_ir32", in_ready32, 64'h1);
    chk("rst_ov32", out_valid32, 64'h0);
    chk("rst_busy32", busy32, 64'h0);
    chk("rst_out32", out32, 64'h0);
    chk("rst_out64", out64, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op({32'h0123_4567, 32'hF0F0_1234}, {32'hFFFF_0000, 32'hFF00_FFFF}, 2'b00);
    run_op(64'h0, 64'h0, 2'b11);
    run_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 2'b10);

    // Back-pressure: result held, new request refused until handshake.
    out_ready = 1'b0;
    ra = 64'h1357_9BDF_2468_ACE0; rb = 64'h0F0F_F0F0_3C3C_C3C3;
    accept_op(ra, rb, 2'b01);
    repeat (8) @(negedge clk);
    chk("bp_ov32", out_valid32, 64'h1);
    chk("bp_out32", out32, {32'h0, model(ra, rb, 2'b01) & 64'hFFFF_FFFF});
    na = 64'hDEAD_BEEF_CAFE_F00D; nb = 64'h1234_5678_9ABC_DEF0;
    a = na; b = nb; op = 2'b10; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_ov32", out_valid32, 64'h1);
      chk("bp_hold_out32", out32, {32'h0, model(ra, rb, 2'b01) & 64'hFFFF_FFFF});
      chk("bp_hold_ir32", in_ready32, 64'h0);
      chk("bp_hold_out64", out64, model(ra, rb, 2'b01));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ov32", out_valid32, 64'h0);
    chk("bp_release_ir32", in_ready32, 64'h1);
    @(negedge clk);
    in_valid = 1'b0; a = 64'h0; b = 64'h0; op = 2'b00;
    complete(na, nb, 2'b10);

    // Asynchronous reset in the middle of BUSY.
    accept_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out32", out32, 64'h0);
    chk("mrst_ov32", out_valid32, 64'h0);
    chk("mrst_ir32", in_ready32, 64'h1);
    chk("mrst_busy32", busy32, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978, 2'b11);

`ifdef SLICED_LOGIC_ZERO_FLAG_EN
    run_op(64'h0F00_0000, 64'hF000_0000, 2'b00);
    run_op(64'h0F00_0000, 64'hF000_0000, 2'b01);
`endif

    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rop = 2'($urandom_range(0, 3));
      run_op(ra, rb, rop);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
